// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
// Shift-add multiplier and restoring divider on operand magnitudes, signs fixed at the end.
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             flush_i,
   input  logic [9:0]       funct_i,
   input  logic [WIDTH-1:0] RS1_i,
   input  logic [WIDTH-1:0] RS2_i,
   input  logic [4:0]       RDaddr_i,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [4:0]       RDaddr_o
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [4:0]         rd_q, rd_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sign_a_q, sign_a_d;
   logic               neg_q, neg_d;
   logic               dz_q, dz_d;
   logic               ovf_q, ovf_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [4:0]         rdo_q, rdo_d;
   logic               done_q, done_d;

   logic [2:0]         op_in;
   logic               a_signed, b_signed, sa, sb;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;
   logic               unused_funct;

   assign unused_funct = ^funct_i[9:3];
   assign op_in    = funct_i[2:0];
   // MUL is taken as signed: the low half is the same either way.
   assign a_signed = !(op_in == 3'b011 || op_in == 3'b101 || op_in == 3'b111);
   assign b_signed = (op_in == 3'b000 || op_in == 3'b001 || op_in == 3'b100 || op_in == 3'b110);
   assign sa       = a_signed & RS1_i[WIDTH-1];
   assign sb       = b_signed & RS2_i[WIDTH-1];

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
   assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
   assign div_ge   = (rem_sh >= {1'b0, b_q});
   assign div_diff = rem_sh - {1'b0, b_q};

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      neg_d    = neg_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      res_d    = res_q;
      rdo_d    = rdo_q;
      done_d   = 1'b0;
      prod     = '0;
      quo      = '0;
      rem      = '0;
      case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               op_d     = op_in;
               rd_d     = RDaddr_i;
               a_d      = sa ? -RS1_i : RS1_i;
               b_d      = sb ? -RS2_i : RS2_i;
               sign_a_d = sa;
               neg_d    = sa ^ sb;
               dz_d     = (RS2_i == '0);
               ovf_d    = (op_in == 3'b100 || op_in == 3'b110) &&
                          (RS1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (RS2_i == '1);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q[2]) begin
               acc_d = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};
               a_d   = a_q << 1;
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               b_d   = b_q >> 1;
            end
            prod = neg_q ? -acc_d : acc_d;
            quo  = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
            rem  = sign_a_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
               rdo_d   = rd_q;
               case (op_q)
                  3'b000:         res_d = prod[WIDTH-1:0];
                  3'b001, 3'b010,
                  3'b011:         res_d = prod[2*WIDTH-1:WIDTH];
                  3'b100, 3'b101: res_d = dz_q ? '1 : (ovf_q ? {1'b1, {(WIDTH-1){1'b0}}} : quo);
                  default:        res_d = ovf_q ? '0 : rem;
               endcase
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) begin
         state_d = IDLE;
         done_d  = 1'b0;
         res_d   = res_q;
         rdo_d   = rdo_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         res_q    <= '0;
         rdo_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         neg_q    <= neg_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         res_q    <= res_d;
         rdo_q    <= rdo_d;
         done_q   <= done_d;
      end
   end

   assign stall_o  = (state_q == IDLE && start_i && !flush_i) || (state_q == CALC);
   assign done_o   = done_q;
   assign result_o = res_q;
   assign RDaddr_o = rdo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed bench for ex_muldiv
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
module tb_ex_muldiv;
   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [9:0]  funct;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd;
   logic        stall, done;
   logic [31:0] result;
   logic [4:0]  rd_out;
   int          ncmp = 0;
   int          nerr = 0;
   logic        seen_done;

   ex_muldiv #(.WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush), .funct_i(funct),
      .RS1_i(rs1), .RS2_i(rs2), .RDaddr_i(rd),
      .stall_o(stall), .done_o(done), .result_o(result), .RDaddr_o(rd_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r);
      start = 1'b1;
      funct = {7'b0000001, f3};
      rs1   = a;
      rs2   = b;
      rd    = r;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
      @(posedge clk); #1;
      present(f3, a, b, r);
      for (int c = 0; c <= 32; c++) begin
         @(negedge clk);
         chk({tag, " stall"}, {31'b0, stall}, 32'd1);
         chk({tag, " early done"}, {31'b0, done}, 32'd0);
         @(posedge clk); #1;
         if (c == 32) start = 1'b0;
      end
      @(negedge clk);
      chk({tag, " done"}, {31'b0, done}, 32'd1);
      chk({tag, " stall in done"}, {31'b0, stall}, 32'd0);
      chk({tag, " result"}, result, exp);
      chk({tag, " rdaddr"}, {27'b0, rd_out}, {27'b0, r});
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " done after"}, {31'b0, done}, 32'd0);
      chk({tag, " result held"}, result, exp);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0;
      funct = '0; rs1 = '0; rs2 = '0; rd = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset done", {31'b0, done}, 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset rdaddr", {27'b0, rd_out}, 32'd0);
      chk("reset stall idle", {31'b0, stall}, 32'd0);
      start = 1'b1; #1;
      chk("reset stall follows start", {31'b0, stall}, 32'd1);
      flush = 1'b1; #1;
      chk("flush masks stall", {31'b0, stall}, 32'd0);
      start = 1'b0; flush = 1'b0;

      run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
      run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000);
      run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF);
      run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD);
      run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF);
      run_op("divu",   3'b101, 32'd100,      32'd7,        5'd11, 32'h0000000E);
      run_op("remu",   3'b111, 32'd100,      32'd7,        5'd12, 32'h00000002);
      run_op("div0",   3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF);
      run_op("remu0",  3'b111, 32'd5,        32'd0,        5'd14, 32'h00000005);
      run_op("rem0s",  3'b110, 32'hFFFFFFF9, 32'd0,        5'd15, 32'hFFFFFFF9);
      run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000);
      run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h00000000);

      // reset in cycle 10 of an op
      @(posedge clk); #1;
      present(3'b000, 32'd3, 32'd4, 5'd9);
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst done", {31'b0, done}, 32'd0);
      chk("rst result", result, 32'd0);
      chk("rst rdaddr", {27'b0, rd_out}, 32'd0);
      chk("rst stall", {31'b0, stall}, 32'd0);
      start = 1'b1; #1;
      chk("rst stall start", {31'b0, stall}, 32'd1);
      start = 1'b0;
      seen_done = 1'b0;
      repeat (30) begin @(negedge clk); if (done) seen_done = 1'b1; end
      chk("rst no done pulse", {31'b0, seen_done}, 32'd0);

      // flush in cycle 10 keeps the previous result
      run_op("pre flush divu", 3'b101, 32'd100, 32'd7, 5'd20, 32'h0000000E);
      @(posedge clk); #1;
      present(3'b111, 32'd100, 32'd7, 5'd21);
      repeat (10) begin @(posedge clk); #1; end
      flush = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush stall", {31'b0, stall}, 32'd0);
      chk("flush done", {31'b0, done}, 32'd0);
      chk("flush result", result, 32'h0000000E);
      seen_done = 1'b0;
      repeat (40) begin @(negedge clk); if (done) seen_done = 1'b1; end
      chk("flush no done pulse", {31'b0, seen_done}, 32'd0);
      chk("flush result kept", result, 32'h0000000E);
      chk("flush rdaddr kept", {27'b0, rd_out}, 32'd20);

      // start held through DONE, back-to-back op in cycle 34
      @(posedge clk); #1;
      present(3'b100, 32'hFFFFFFF9, 32'd2, 5'd3);
      for (int c = 0; c <= 32; c++) begin
         @(negedge clk);
         chk("b2b first stall", {31'b0, stall}, 32'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("b2b first done", {31'b0, done}, 32'd1);
      chk("b2b first result", result, 32'hFFFFFFFD);
      chk("b2b no stall in done", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      present(3'b101, 32'd9, 32'd4, 5'd12);
      @(negedge clk);
      chk("b2b accept stall", {31'b0, stall}, 32'd1);
      chk("b2b cycle34 done", {31'b0, done}, 32'd0);
      for (int c = 35; c <= 67; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         @(negedge clk);
         if (c < 67) begin
            chk("b2b second stall", {31'b0, stall}, 32'd1);
            chk("b2b second early done", {31'b0, done}, 32'd0);
         end
      end
      chk("b2b second done", {31'b0, done}, 32'd1);
      chk("b2b second result", result, 32'h00000002);
      chk("b2b second rdaddr", {27'b0, rd_out}, 32'd12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
